// File: rtl/pwd_pkg.sv
// Shared types and constants for the blink/PWM mode scheduler.
// Optional auto-advance is enabled in pwd_sched by defining PWD_SCHED_AUTO_EN.
package pwd_pkg;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_BLANK = 1'b1
    } state_t;

    localparam int N_MODES_DEF  = 9;
    localparam int TICK_DIV_DEF = 10000000;
    localparam int MAX_MODES    = 16;

    // Fixed-width one-hot; callers slice down to their own mode count.
    function automatic logic [MAX_MODES-1:0] onehot(input logic [3:0] idx);
        logic [MAX_MODES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pwd_tick_gen.sv
// Free-running tick divider: one-cycle tick every TICK_DIV clocks, restartable.
module pwd_tick_gen #(
    parameter int TICK_DIV = pwd_pkg::TICK_DIV_DEF
) (
    input  logic clk,
    input  logic _rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // tick is registered from the next count, so it is high exactly while the count sits at LAST.
    always_comb begin
        if (restart || cnt_q == LAST) cnt_d = '0;
        else                          cnt_d = cnt_q + 1'b1;
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/pwd_sched.sv
// Mode scheduler: steps a one-hot counter-bank select with clear and blanking.
// Define PWD_SCHED_AUTO_EN to build the auto-advance (slideshow) logic.
module pwd_sched
    import pwd_pkg::*;
#(
    parameter int N_MODES     = N_MODES_DEF,
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int BLANK_TICKS = 2,
    parameter int DWELL_TICKS = 8
) (
    input  logic                       clk,
    input  logic                       _rst,
    input  logic                       btn_next,
    input  logic                       btn_prev,
    output logic [N_MODES-1:0]         sel,
    output logic [$clog2(N_MODES)-1:0] idx,
    output logic                       clr,
    output logic                       tick,
    output logic                       auto_on
);

    localparam int            IW         = $clog2(N_MODES);
    localparam int            BW         = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [IW-1:0] IDX_MAX    = IW'(N_MODES - 1);

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d, idx_step;
    logic [N_MODES-1:0]   sel_q, sel_d;
    logic                 clr_q, clr_d;
    logic [BW-1:0]        blank_q, blank_d;
    logic [MAX_MODES-1:0] oh_step, oh_cur;
    logic                 man_next, man_prev, both, auto_adv, step;

    assign man_next = btn_next & ~btn_prev;
    assign man_prev = btn_prev & ~btn_next;
    assign both     = btn_next & btn_prev;
    // A button always wins over the slideshow; an auto-advance can only ever step forward.
    assign step     = man_next | man_prev | (auto_adv & ~both);

    always_comb begin
        if (man_prev) idx_step = (idx_q == '0) ? IDX_MAX : idx_q - 1'b1;
        else          idx_step = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    assign oh_step = onehot(4'(idx_step));
    assign oh_cur  = onehot(4'(idx_q));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        clr_d   = 1'b0;
        blank_d = blank_q;
        if (step) begin
            idx_d   = idx_step;
            clr_d   = 1'b1;
            blank_d = '0;
            if (BLANK_TICKS > 0) begin
                sel_d   = '0;
                state_d = S_BLANK;
            end else begin
                sel_d   = oh_step[N_MODES-1:0];
                state_d = S_RUN;
            end
        end else if (state_q == S_BLANK && tick) begin
            if (blank_q == BLANK_LAST) begin
                state_d = S_RUN;
                sel_d   = oh_cur[N_MODES-1:0];
                blank_d = '0;
            end else begin
                blank_d = blank_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            sel_q   <= N_MODES'(1);
            clr_q   <= 1'b0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            clr_q   <= clr_d;
            blank_q <= blank_d;
        end
    end

`ifdef PWD_SCHED_AUTO_EN
    localparam int            DW         = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

    logic          auto_q, auto_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          run_tick;

    // Dwell only advances on ticks seen while the new mode is actually displayed.
    assign run_tick = auto_q & (state_q == S_RUN) & tick;
    assign auto_adv = run_tick & (dwell_q == DWELL_LAST);

    always_comb begin
        auto_d  = auto_q;
        dwell_d = dwell_q;
        if (both) begin
            auto_d  = ~auto_q;
            dwell_d = '0;
        end else if (step) begin
            dwell_d = '0;
        end else if (run_tick) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            auto_q  <= 1'b0;
            dwell_q <= '0;
        end else begin
            auto_q  <= auto_d;
            dwell_q <= dwell_d;
        end
    end

    assign auto_on = auto_q;
`else
    assign auto_adv = 1'b0;
    assign auto_on  = 1'b0;
`endif

    pwd_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        ._rst    (_rst),
        .restart (step),
        .tick    (tick)
    );

    assign sel = sel_q;
    assign idx = idx_q;
    assign clr = clr_q;

endmodule

// File: tb/tb_pwd_sched.sv
// Randomized bench for pwd_sched against a cycle-indexed behavioural model.
module tb_pwd_sched;

    localparam int N  = 9;
    localparam int TD = 4;
    localparam int BT = 2;
    localparam int DT = 3;
`ifdef PWD_SCHED_AUTO_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         btn_next = 1'b0;
    logic         btn_prev = 1'b0;
    logic [N-1:0] sel;
    logic [3:0]   idx;
    logic         clr, tick, auto_on;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: tick phase, blank end and last step are kept as absolute cycle numbers.
    int m_idx, m_rs, m_bend, m_lstep, m_dwell;
    bit m_auto;

    pwd_sched #(
        .N_MODES     (N),
        .TICK_DIV    (TD),
        .BLANK_TICKS (BT),
        .DWELL_TICKS (DT)
    ) dut (
        .clk      (clk),
        ._rst     (rst_n),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .sel      (sel),
        .idx      (idx),
        .clr      (clr),
        .tick     (tick),
        .auto_on  (auto_on)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit m_tick(input int c);
        return (c >= m_rs) && ((c - m_rs) % TD == TD - 1);
    endfunction

    task automatic check_all();
        chk("idx",  32'(idx), 32'(m_idx));
        chk("sel",  32'(sel), (cyc >= m_bend) ? (32'd1 << m_idx) : 32'd0);
        chk("clr",  32'(clr), 32'(cyc == m_lstep + 1));
        chk("tick", 32'(tick), 32'(m_tick(cyc)));
        chk("auto", 32'(auto_on), 32'(m_auto));
    endtask

    task automatic do_step(input bit fwd);
        m_idx   = fwd ? (m_idx + 1) % N : (m_idx + N - 1) % N;
        m_rs    = cyc + 1;
        m_bend  = cyc + 1 + BT * TD;
        m_lstep = cyc;
        m_dwell = 0;
    endtask

    task automatic model_update(input logic bn, input logic bp);
        bit tk, run, adv;
        tk  = m_tick(cyc);
        run = (cyc >= m_bend);
        adv = AUTO && m_auto && run && tk && (m_dwell == DT - 1);
        if (bn != bp) begin
            do_step(bn);
        end else if (bn && bp) begin
            if (AUTO) begin
                m_auto  = !m_auto;
                m_dwell = 0;
            end
        end else if (adv) begin
            do_step(1'b1);
        end else if (AUTO && m_auto && run && tk) begin
            m_dwell++;
        end
    endtask

    task automatic cyc1(input logic bn, input logic bp);
        @(negedge clk);
        check_all();
        btn_next = bn;
        btn_prev = bp;
        @(posedge clk);
        model_update(bn, bp);
        cyc++;
    endtask

    // Asserts reset mid-cycle, checks the outputs before any clock edge, then releases at a negedge.
    task automatic do_reset();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sel",  32'(sel), 32'h001);
        chk("rst_idx",  32'(idx), 32'd0);
        chk("rst_clr",  32'(clr), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_auto", 32'(auto_on), 32'd0);
        m_idx   = 0;
        m_auto  = 1'b0;
        m_dwell = 0;
        m_lstep = -100;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        rst_n  = 1'b1;
        m_rs   = cyc;
        m_bend = cyc;
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        do_reset();
        repeat (8) cyc1(1'b0, 1'b0);

        // next, prev back to 0, prev wrap to 8, next wrap to 0
        cyc1(1'b1, 1'b0); repeat (12) cyc1(1'b0, 1'b0);
        cyc1(1'b0, 1'b1); repeat (12) cyc1(1'b0, 1'b0);
        cyc1(1'b0, 1'b1); repeat (12) cyc1(1'b0, 1'b0);
        cyc1(1'b1, 1'b0); repeat (12) cyc1(1'b0, 1'b0);

        // second step five cycles into the blank restarts it
        cyc1(1'b1, 1'b0); repeat (4) cyc1(1'b0, 1'b0);
        cyc1(1'b1, 1'b0); repeat (12) cyc1(1'b0, 1'b0);

        // auto toggle on, run past a full wrap, toggle off
        cyc1(1'b1, 1'b1); repeat (200) cyc1(1'b0, 1'b0);
        cyc1(1'b1, 1'b1); repeat (10) cyc1(1'b0, 1'b0);

        repeat (3000) begin
            r = $urandom_range(0, 99);
            cyc1((r < 5) || (r >= 10 && r < 12), (r >= 5 && r < 12));
        end
        cyc1(1'b0, 1'b0);

        // reach mode 5, then reset in the middle of its blank
        do_reset();
        repeat (5) begin
            cyc1(1'b1, 1'b0);
            cyc1(1'b0, 1'b0);
            cyc1(1'b0, 1'b0);
        end
        cyc1(1'b0, 1'b0);
        chk("pre_rst_idx", 32'(idx), 32'd5);
        chk("pre_rst_sel", 32'(sel), 32'd0);
        do_reset();
        repeat (10) cyc1(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
